// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   state_e : arbiter FSM states (IDLE, OWN, GAP)
//   NULL    : end-of-message character value
//   clog2   : counter width helper, never returns less than 1
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int NULL = 0;

    // Width needed to hold values 0..value-1; at least one bit so that
    // degenerate parameters still give a legal vector.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// one position after the previous owner and wrapping around.
// Ports:
//   req       in  NumReq : request levels
//   last      in  IdxW   : index of the previous owner
//   winner    out NumReq : one-hot winner, zero when no request
//   winnerIdx out IdxW   : index of the winner, zero when no request
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdxW   = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last,
    output logic [NumReq-1:0] winner,
    output logic [IdxW-1:0]   winnerIdx
);

    logic found;

    function automatic logic [IdxW-1:0] wrapIdx(input int value);
        return IdxW'(value % NumReq);
    endfunction

    // First asserted request after 'last'; the previous owner itself is
    // checked last so it only wins again when nobody else is asking.
    always_comb begin
        winner    = '0;
        winnerIdx = '0;
        found     = 1'b0;
        for (int j = 1; j <= NumReq; j++) begin
            if (!found && req[wrapIdx(int'(last) + j)]) begin
                found                            = 1'b1;
                winner[wrapIdx(int'(last) + j)]  = 1'b1;
                winnerIdx                        = wrapIdx(int'(last) + j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between several character-stream requesters.
// Ownership is granted round-robin for a whole message; accepted characters
// are forwarded as one-cycle write strobes followed by a fixed gap.
// Ports:
//   clock         in  : rising-edge clock
//   reset         in  : asynchronous active-low reset
//   req           in  : per-requester message request (level)
//   wr            in  : per-requester character valid
//   data          in  : packed characters, requester i at [i*DataBits +: DataBits]
//   tx_full       in  : UART FIFO full
//   grant         out : registered one-hot owner
//   ready         out : combinational per-requester accept enable
//   write_to_uart out : registered one-cycle write strobe
//   w_data        out : registered character for the strobe
//   busy          out : registered, high while not IDLE
//   timeout       out : registered pulse on idle revocation
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataBits  = 7,
    parameter int GapCycles = 16,
    parameter int IdleLimit = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NumReq-1:0]          req,
    input  logic [NumReq-1:0]          wr,
    input  logic [NumReq*DataBits-1:0] data,
    input  logic                       tx_full,
    output logic [NumReq-1:0]          grant,
    output logic [NumReq-1:0]          ready,
    output logic                       write_to_uart,
    output logic [DataBits-1:0]        w_data,
    output logic                       busy,
    output logic                       timeout
);

    localparam int IdxW  = clog2(NumReq);
    localparam int GapW  = clog2(GapCycles);
    localparam int IdleW = clog2(IdleLimit);

    state_e              state_q;
    logic [NumReq-1:0]   grant_q;
    logic [IdxW-1:0]     owner_q;
    logic [IdxW-1:0]     last_q;
    logic [GapW-1:0]     gapCnt_q;
    logic [GapW-1:0]     gapCnt_d;
    logic [IdleW-1:0]    idleCnt_q;
    logic [IdleW-1:0]    idleCnt_d;
    logic                strobe_q;
    logic [DataBits-1:0] wData_q;
    logic                busy_q;
    logic                timeout_q;

    logic [NumReq-1:0]   pickOneHot;
    logic [IdxW-1:0]     pickIdx;
    logic [DataBits-1:0] ownerData;
    logic                ownerReq;
    logic                ownReady;
    logic                accept;

    rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .req       (req),
        .last      (last_q),
        .winner    (pickOneHot),
        .winnerIdx (pickIdx)
    );

    // The owner's view of the request bus, and the accept condition that
    // gates every character into the UART path.
    always_comb begin
        ownerData = data[int'(owner_q)*DataBits +: DataBits];
        ownerReq  = req[owner_q];
        ownReady  = (state_q == OWN) && !tx_full;
        accept    = ownReady && wr[owner_q];
        ready     = ownReady ? grant_q : '0;
        gapCnt_d  = gapCnt_q - 1'b1;
        idleCnt_d = idleCnt_q + 1'b1;
    end

    // Arbiter FSM with all outputs registered. Strobe and timeout default
    // low each cycle so they can only ever be one-cycle pulses. Every way
    // out of ownership records the owner as 'last' for the next search.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= IdxW'(NumReq - 1);
            gapCnt_q  <= '0;
            idleCnt_q <= '0;
            strobe_q  <= 1'b0;
            wData_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q   <= OWN;
                        grant_q   <= pickOneHot;
                        owner_q   <= pickIdx;
                        busy_q    <= 1'b1;
                        idleCnt_q <= '0;
                    end
                end
                OWN: begin
                    if (accept) begin
                        if (ownerData == DataBits'(NULL)) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            last_q  <= owner_q;
                        end else begin
                            strobe_q <= 1'b1;
                            wData_q  <= ownerData;
                            gapCnt_q <= GapW'(GapCycles - 1);
                            state_q  <= GAP;
                        end
                    end else if (!ownerReq) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= owner_q;
                    end else if (idleCnt_q == IdleW'(IdleLimit - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        last_q    <= owner_q;
                    end else begin
                        idleCnt_q <= idleCnt_d;
                    end
                end
                GAP: begin
                    // A release seen at the end of the gap still lets the
                    // full gap elapse before anyone else can be granted.
                    if (gapCnt_q == '0) begin
                        if (ownerReq) begin
                            state_q   <= OWN;
                            idleCnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            last_q  <= owner_q;
                        end
                    end else begin
                        gapCnt_q <= gapCnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign write_to_uart = strobe_q;
    assign w_data        = wData_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between up to `NumReq` character-stream requesters (e.g. several memory-to-serial senders). Grants the UART to one requester at a time for a whole message, using round-robin order. Forwards that requester's characters as single-cycle `write_to_uart` strobes, honouring `tx_full`, and enforces a minimum inter-character gap. Ownership ends on release, on a NULL character, or on an idle timeout.

## Interface
- `NumReq`, default 4: number of requesters, 2..8.
- `DataBits`, default 7: character width.
- `GapCycles`, default 16: cycles after each write during which no new character is accepted; must be ≥1.
- `IdleLimit`, default 1024: cycles without an accepted character before ownership is revoked; must be ≥2.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state immediately.
- `req`  in  NumReq: per-requester message request, level, held for the whole message.
- `wr`  in  NumReq: per-requester character-valid strobe.
- `data`  in  NumReq*DataBits: requester i's character at bits [i*DataBits +: DataBits].
- `tx_full`  in  1: UART transmit FIFO full.
- `grant`  out  NumReq: one-hot owner, registered; all zero when no owner.
- `ready`  out  NumReq: combinational; `ready[i] = grant[i] & (state==OWN) & ~tx_full`.
- `write_to_uart`  out  1: registered one-cycle write strobe to the UART.
- `w_data`  out  DataBits: registered character, valid while `write_to_uart`=1.
- `busy`  out  1: registered; 1 whenever state≠IDLE.
- `timeout`  out  1: registered one-cycle pulse when ownership is revoked by `IdleLimit`.

## Operation
- **State values on reset:** state=IDLE, `grant`=0, `write_to_uart`=0, `w_data`=0, `busy`=0, `timeout`=0, gap/idle counters 0, round-robin pointer `last`=NumReq-1, so requester 0 has first priority.
- **IDLE:**
  - If `req`≠0, pick the first asserted requester searching from `last`+1 modulo NumReq.
  - Set its `grant` bit and go to OWN. Clear the idle counter.
- **OWN:**
  - Accept when `wr[g] & ready[g]`.
  - If the accepted `data`==NULL (0), there is no UART write: set `last`=g, clear `grant`, go to IDLE.
  - Otherwise, on the next edge: `write_to_uart`=1, `w_data`=data, gap counter=GapCycles-1, go to GAP.
  - If `req[g]`=0 and there is no accept: set `last`=g, clear `grant`, go to IDLE.
  - Otherwise the idle counter increments. When it reaches IdleLimit-1: pulse `timeout`, set `last`=g, clear `grant`, go to IDLE.
- **GAP:**
  - `grant` is held and `ready` is 0.
  - The counter decrements each cycle. At 0, go to OWN and clear the idle counter.
  - If `req[g]` dropped during GAP, go to IDLE instead. The gap is always completed before any new grant.
- `wr` from non-owners and `wr` while `ready`=0 are ignored. The character is not accepted.
- `tx_full` is sampled only through `ready`. A write strobe is never issued for a character that was not accepted.

## Timing
- `req` rises in cycle 0 while IDLE → `grant`/`busy` high in cycle 1. `ready` can be high in cycle 1.
- Accept in cycle k → `write_to_uart`=1 only in cycle k+1. GAP covers cycles k+1..k+GapCycles. Next accept is possible at k+GapCycles+1, so the maximum rate is one character per GapCycles+1 cycles.
- Release: `req[g]` low in cycle k while in OWN → `grant`=0 in cycle k+1 (IDLE). The earliest new grant is in cycle k+2.
- NULL acceptance behaves the same as release: IDLE at k+1, no strobe.
- If `tx_full` and `wr` rise in the same cycle, there is no accept. The character is held by the requester until `ready` returns.
- If `req[g]` drops in the same cycle as an accept, the accept wins. The block enters GAP, then goes to IDLE after the gap.
- If multiple requests arrive at once in IDLE, only the round-robin winner is granted and the others wait.
- Reset asserted mid-GAP or mid-strobe: all outputs reach their reset values immediately. No partial strobe occurs after release.

## Structure
- Package `uart_arb_pkg`:
  - state encoding IDLE=2'd0, OWN=2'd1, GAP=2'd2;
  - `NULL`=0;
  - counter-width function `clog2`.
- Sub-module `rr_pick`: combinational, with inputs `req` and `last` and a one-hot winner output plus its index. It is instantiated once.
- Counters:
  - gap counter width is clog2(GapCycles);
  - idle counter width is clog2(IdleLimit).

## Test plan
- **Reset and single message:** reset, then requester 1 sends "Hi" followed by NULL with `tx_full`=0 → `grant`=4'b0010 one cycle after `req`, two strobes with `w_data`=7'h48 then 7'h69 spaced GapCycles+1=17 cycles apart, `grant`=0 the cycle after NULL, and no third strobe.
- **Round robin:** `req`=4'b1111 held, each owner sends one character then NULL → grant order 0,1,2,3,0; each owner is granted exactly once per rotation.
- **Backpressure:** `tx_full`=1 for 50 cycles while the owner holds `wr` with 7'h41 → `ready`=0 and no strobe during those cycles; exactly one strobe with 7'h41 on the cycle after the accept once `tx_full` falls.
- **Idle timeout:** with IdleLimit=8, the owner holds `req` and never writes → `timeout` pulses once, `grant` clears, and the next requester is granted two cycles later.
- **Release during gap:** the owner drops `req` one cycle after an accept → the gap still lasts 16 cycles, then the block goes to IDLE; a waiting requester is granted no earlier than 18 cycles after the accept.
- **Asynchronous reset mid-GAP:** `reset`=0 between edges → `grant`, `busy`, and `write_to_uart` go to 0 without a clock edge; after release, requester 0 has priority again.
